// File: rtl/mem_responder_if.sv
// Memory bus between the rv32 core (master) and the word memory responder (slave).
interface mem_responder_if #(
    parameter int unsigned ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic                  mem_rd;
    logic                  mem_wr;
    logic [31:0]           mem_rdata;
    logic                  mem_rvalid;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_rd,
        output mem_wr,
        input  mem_rdata,
        input  mem_rvalid
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_rd,
        input  mem_wr,
        output mem_rdata,
        output mem_rvalid
    );
endinterface

// File: rtl/mem_responder.sv
// Single-port word memory answering the core's registered rd/wr strobes. Read data is
// registered one edge after the strobe and held until the next accepted read. Illegal
// accesses are recorded by a sticky two-state error FSM.
module mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter string       INIT_FILE   = ""
) (
    input  logic                  clk,
    input  logic                  reset,
    mem_responder_if.slave        bus,
    input  logic                  err_clr,
    output logic                  err,
    output logic [ADDR_WIDTH-1:0] err_addr,
    output logic [1:0]            err_code
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    // One extra bit so the byte limit never wraps when compared against the address.
    localparam logic [ADDR_WIDTH:0] ByteLimit = (ADDR_WIDTH + 1)'(4 * DEPTH_WORDS);

    localparam logic [1:0] CodeMisaligned = 2'b01;
    localparam logic [1:0] CodeRange      = 2'b10;
    localparam logic [1:0] CodeBoth       = 2'b11;

    typedef enum logic [0:0] {StClear, StLatched} err_state_e;

    logic [31:0]           mem_q [DEPTH_WORDS];
    logic [31:0]           rdata_q, rdata_d;
    logic                  rvalid_q, rvalid_d;
    logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
    logic [1:0]            err_code_q, err_code_d;
    err_state_e            state_q, state_d;
    // Low in reset and on the release edge, so a strobe sampled there is ignored.
    logic                  run_q;

    logic [AW-1:0] idx;
    logic          misaligned;
    logic          in_range;
    logic          addr_ok;
    logic          both;
    logic          do_read;
    logic          do_write;
    logic          illegal;
    logic [1:0]    cause;

    // Decode the current strobe: legality, cause and which operations proceed.
    always_comb begin
        idx        = bus.mem_addr[AW+1:2];
        misaligned = |bus.mem_addr[1:0];
        in_range   = {1'b0, bus.mem_addr} < ByteLimit;
        addr_ok    = !misaligned && in_range;
        both       = bus.mem_rd && bus.mem_wr;
        do_read    = run_q && bus.mem_rd && !bus.mem_wr;
        do_write   = run_q && bus.mem_wr && addr_ok;
        illegal    = run_q && (both || ((bus.mem_rd || bus.mem_wr) && !addr_ok));
        if (both) begin
            cause = CodeBoth;
        end else if (misaligned) begin
            cause = CodeMisaligned;
        end else begin
            cause = CodeRange;
        end
    end

    // Read path next state: illegal reads return zero but still pulse valid.
    always_comb begin
        rdata_d  = rdata_q;
        rvalid_d = do_read;
        if (do_read) begin
            rdata_d = addr_ok ? mem_q[idx] : 32'h0;
        end
    end

    // Error FSM next state; a clear coinciding with a new error recaptures and stays latched.
    always_comb begin
        state_d    = state_q;
        err_addr_d = err_addr_q;
        err_code_d = err_code_q;
        unique case (state_q)
            StClear: begin
                if (illegal) begin
                    state_d    = StLatched;
                    err_addr_d = bus.mem_addr;
                    err_code_d = cause;
                end
            end
            StLatched: begin
                if (err_clr) begin
                    if (illegal) begin
                        err_addr_d = bus.mem_addr;
                        err_code_d = cause;
                    end else begin
                        state_d = StClear;
                    end
                end
            end
            default: state_d = StClear;
        endcase
    end

    // Control and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_q      <= 1'b0;
            rdata_q    <= 32'h0;
            rvalid_q   <= 1'b0;
            err_addr_q <= '0;
            err_code_q <= 2'b00;
            state_q    <= StClear;
        end else begin
            run_q      <= 1'b1;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
            err_addr_q <= err_addr_d;
            err_code_q <= err_code_d;
            state_q    <= state_d;
        end
    end

    // Storage array; deliberately not reset so contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem_q[idx] <= bus.mem_wdata;
        end
    end

    assign bus.mem_rdata  = rdata_q;
    assign bus.mem_rvalid = rvalid_q;
    assign err            = (state_q == StLatched);
    assign err_addr       = err_addr_q;
    assign err_code       = err_code_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: read data expectations go through a scoreboard queue.
module tb_mem_responder;

    logic        clk;
    logic        reset;
    logic        err_clr;
    logic        err;
    logic [31:0] err_addr;
    logic [1:0]  err_code;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    mem_responder_if #(.ADDR_WIDTH(32)) bus ();

    mem_responder #(
        .DEPTH_WORDS(1024),
        .ADDR_WIDTH (32),
        .INIT_FILE  ("")
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus.slave),
        .err_clr (err_clr),
        .err     (err),
        .err_addr(err_addr),
        .err_code(err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One bus cycle: drive at negedge, sample 1 time unit after the rising edge.
    task automatic step(input logic rd, input logic wr, input logic clr,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp);
        logic [31:0] want;
        @(negedge clk);
        bus.mem_rd    = rd;
        bus.mem_wr    = wr;
        bus.mem_addr  = addr;
        bus.mem_wdata = wd;
        err_clr       = clr;
        if (rd && !wr) exp_q.push_back(exp);
        @(posedge clk);
        #1;
        bus.mem_rd = 1'b0;
        bus.mem_wr = 1'b0;
        err_clr    = 1'b0;
        check("rvalid", {31'b0, bus.mem_rvalid}, {31'b0, rd && !wr});
        if (bus.mem_rvalid) begin
            if (exp_q.size() == 0) begin
                check("rvalid_without_expectation", 32'h1, 32'h0);
            end else begin
                want = exp_q.pop_front();
                check("rdata", bus.mem_rdata, want);
            end
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic check_err(input string tag, input logic e, input logic [31:0] a,
                             input logic [1:0] c);
        check({tag, "_err"}, {31'b0, err}, {31'b0, e});
        check({tag, "_addr"}, err_addr, a);
        check({tag, "_code"}, {30'b0, err_code}, {30'b0, c});
    endtask

    initial begin
        reset         = 1'b0;
        err_clr       = 1'b0;
        bus.mem_rd    = 1'b0;
        bus.mem_wr    = 1'b0;
        bus.mem_addr  = 32'h0;
        bus.mem_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rdata", bus.mem_rdata, 32'h0);
        check("reset_rvalid", {31'b0, bus.mem_rvalid}, 32'h0);
        check_err("reset", 1'b0, 32'h0, 2'b00);
        @(negedge clk);
        reset = 1'b1;
        idle();
        idle();

        // Preload word 0 with an instruction, then read it back and confirm it is held.
        step(1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_0013, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0000_0013);
        idle();
        idle();
        idle();
        check("read0_held", bus.mem_rdata, 32'h0000_0013);

        // Write then read on the very next edge.
        step(1'b0, 1'b1, 1'b0, 32'h40, 32'hDEAD_BEEF, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 32'hDEAD_BEEF);
        check_err("wr_rd", 1'b0, 32'h0, 2'b00);

        // Misaligned read: zero data, still valid, error captured.
        step(1'b1, 1'b0, 1'b0, 32'h42, 32'h0, 32'h0);
        check_err("misaligned", 1'b1, 32'h42, 2'b01);
        // Out-of-range write aliases word 0 by index; it must be dropped and not recaptured.
        step(1'b0, 1'b1, 1'b0, 32'h1_0000, 32'hAAAA_5555, 32'h0);
        check_err("oor_wr_latched", 1'b1, 32'h42, 2'b01);
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0000_0013);

        // Clear; capture registers keep their values.
        step(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0);
        check_err("cleared", 1'b0, 32'h42, 2'b01);

        // rd and wr together: write happens, read suppressed, code 11.
        step(1'b1, 1'b1, 1'b0, 32'h8, 32'h1234_5678, 32'h0);
        check("both_rdata_held", bus.mem_rdata, 32'h0000_0013);
        check_err("both", 1'b1, 32'h8, 2'b11);
        step(1'b1, 1'b0, 1'b0, 32'h8, 32'h0, 32'h1234_5678);

        // Clear coinciding with a new misaligned access recaptures and stays latched.
        step(1'b1, 1'b0, 1'b1, 32'h6, 32'h0, 32'h0);
        check_err("clr_and_err", 1'b1, 32'h6, 2'b01);
        step(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0);
        check_err("clr2", 1'b0, 32'h6, 2'b01);

        // First out-of-range word address.
        step(1'b1, 1'b0, 1'b0, 32'h1000, 32'h0, 32'h0);
        check_err("oor_rd", 1'b1, 32'h1000, 2'b10);
        // Last legal word is in range and readable.
        step(1'b0, 1'b1, 1'b1, 32'hFFC, 32'hCAFE_F00D, 32'h0);
        check_err("last_word_clr", 1'b0, 32'h1000, 2'b10);
        step(1'b1, 1'b0, 1'b0, 32'hFFC, 32'h0, 32'hCAFE_F00D);

        // Reset between a read strobe and its sampling edge.
        @(negedge clk);
        bus.mem_rd   = 1'b1;
        bus.mem_addr = 32'h40;
        #2;
        reset = 1'b0;
        #1;
        check("midreset_rdata", bus.mem_rdata, 32'h0);
        check("midreset_rvalid", {31'b0, bus.mem_rvalid}, 32'h0);
        @(posedge clk);
        #1;
        bus.mem_rd = 1'b0;
        check("midreset_rdata_edge", bus.mem_rdata, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        idle();
        idle();
        step(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 32'hDEAD_BEEF);

        // Fetch sequence: program words, then read each and sample at the decode edge.
        step(1'b0, 1'b1, 1'b0, 32'h4, 32'h0010_0093, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h8, 32'h0020_0113, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'hC, 32'h0020_81B3, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0000_0013);
        idle();
        check("decode_pc0", bus.mem_rdata, 32'h0000_0013);
        step(1'b1, 1'b0, 1'b0, 32'h4, 32'h0, 32'h0010_0093);
        idle();
        check("decode_pc4", bus.mem_rdata, 32'h0010_0093);
        step(1'b1, 1'b0, 1'b0, 32'h8, 32'h0, 32'h0020_0113);
        idle();
        check("decode_pc8", bus.mem_rdata, 32'h0020_0113);
        step(1'b1, 1'b0, 1'b0, 32'hC, 32'h0, 32'h0020_81B3);
        idle();
        check("decode_pcc", bus.mem_rdata, 32'h0020_81B3);

        // Back-to-back reads on consecutive edges.
        step(1'b1, 1'b0, 1'b0, 32'hC, 32'h0, 32'h0020_81B3);
        step(1'b1, 1'b0, 1'b0, 32'h4, 32'h0, 32'h0010_0093);
        idle();

        check("scoreboard_empty", exp_q.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
